// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan display and its BCD converter.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } conv_state_e;

  localparam logic [7:0] SEG_BLANK        = 8'hFF;
  localparam int         SCAN_DIV_DEFAULT = 100000;

  // Active-low glyphs for 0-F with the decimal point off.
  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // A lit digit gets its glyph plus a decimal point that lights on overflow.
  function automatic logic [7:0] seg_encode(input logic [3:0] nib,
                                            input logic       blank,
                                            input logic       ovf);
    logic [7:0] g;
    g = GLYPH[nib];
    if (blank) return SEG_BLANK;
    return {~ovf, g[6:0]};
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Value/mode inputs and segment/anode outputs of the scan display.
interface seg_scan_display_if;
  logic        mod;
  logic [31:0] data;
  logic [7:0]  SEG;
  logic [7:0]  AN;
  logic        busy;

  modport master (output mod, output data, input SEG, input AN, input busy);
  modport slave  (input mod, input data, output SEG, output AN, output busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 10-digit BCD converter (double-dabble, one bit per clock).
// done is high during the cycle whose clock edge performs the final shift;
// bcd holds the complete result from the next cycle until the next start.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        done,
  output logic [39:0] bcd
);

  logic [31:0] shift_q, shift_d;
  logic [39:0] acc_q, acc_d;
  logic [39:0] adj;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;

  // Load on start, otherwise add-3-then-shift once per cycle for 32 cycles.
  always_comb begin
    adj     = acc_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    for (int i = 0; i < 10; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    if (start) begin
      shift_d = bin;
      acc_d   = '0;
      cnt_d   = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      acc_d   = (adj << 1) | {39'b0, shift_q[31]};
      shift_d = {shift_q[30:0], 1'b0};
      cnt_d   = cnt_q + 5'd1;
      if (cnt_q == 5'd31) run_d = 1'b0;
    end
  end

  // Converter registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  assign done = run_q && (cnt_q == 5'd31);
  assign bcd  = acc_q;

endmodule

// File: rtl/seg_scan_display.sv
// 8-digit multiplexed seven-segment driver: hex passthrough or blanked unsigned decimal.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int CNT_W    = 17
) (
  input  logic               clk,
  input  logic               clr_n,
  seg_scan_display_if.slave  bus
);

  conv_state_e     state_q, state_d;
  logic [7:0][3:0] dig_q, dig_d;
  logic [7:0]      blank_q, blank_d;
  logic            ovf_q, ovf_d;
  logic            start;
  logic            bcd_done;
  logic [39:0]     bcd;
  logic [7:0]      bcd_blank;
  logic            nonzero_seen;

  logic [CNT_W-1:0] pre_q, pre_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .clr_n (clr_n),
    .start (start),
    .bin   (bus.data),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // Leading-zero blanking: digit k blanks when every digit from 7 down to k is zero.
  always_comb begin
    bcd_blank    = '0;
    nonzero_seen = 1'b0;
    for (int k = 7; k >= 1; k--) begin
      nonzero_seen = nonzero_seen | (bcd[4*k +: 4] != 4'd0);
      bcd_blank[k] = ~nonzero_seen;
    end
  end

  // Conversion sequencing; the display register only changes in IDLE (hex) or DONE (decimal).
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mod) begin
          dig_d   = bus.data;
          blank_d = '0;
          ovf_d   = 1'b0;
        end else begin
          start   = 1'b1;
          state_d = CONV;
        end
      end
      CONV: if (bcd_done) state_d = DONE;
      DONE: begin
        dig_d   = bcd[31:0];
        ovf_d   = |bcd[39:32];
        blank_d = bcd_blank;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Conversion state and display register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      dig_q   <= '0;
      blank_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
    end
  end

  // Scan timing: hold each digit SCAN_DIV clocks, then step to the next one.
  always_comb begin
    pre_d = pre_q + CNT_W'(1);
    idx_d = idx_q;
    if (pre_q == CNT_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 3'd1;
    end
    an_d  = ~(8'b1 << idx_q);
    seg_d = seg_encode(dig_q[idx_q], blank_q[idx_q], ovf_q);
  end

  // Scanner registers; outputs stay dark while reset is held.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= 8'hFF;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.SEG  = seg_q;
  assign bus.AN   = an_q;
  assign bus.busy = (state_q == CONV);

endmodule
